delay_probe_rx: RTL
===================

Name: delay_probe_rx

Overview:
- Receive-side counterpart of the delay-test frame generator.
- Sits on the MAC's 32-bit Avalon-ST RX source (SHIFT16 alignment enabled) in the 125 MHz MAC clock domain.
- Parses each test frame, extracts the sequence number and the 64-bit transmit timestamp, and computes one-way/loopback delay against the local free-running timestamp.
- Tracks lost, out-of-order and errored frames for CSR readout.

Parameters:
- ETHERTYPE, 16'h88B5, EtherType identifying test frames.
- LOCAL_MAC, 48'h000000000000, destination MAC accepted when filtering is compiled in.
- CNT_W, 32, width of all statistics counters.

Ports:
- clk_i  in  1  MAC RX-side system clock, 125 MHz.
- srst_i  in  1  synchronous reset, active-high.
- ts_i  in  64  free-running timestamp, same clock domain as the generator's copy.
- snk_data_i  in  32  Avalon-ST data; first byte on [31:24].
- snk_valid_i  in  1  data valid.
- snk_sop_i  in  1  start of packet.
- snk_eop_i  in  1  end of packet.
- snk_empty_i  in  2  empty bytes on eop word.
- snk_error_i  in  6  MAC error flags; any bit set on eop word = bad frame.
- snk_ready_o  out  1  sink ready.
- res_valid_o  out  1  one-cycle pulse, result fields valid.
- res_seq_o  out  32  sequence number of the measured frame.
- res_delay_o  out  32  delay in ts_i ticks, saturated.
- cnt_rx_o  out  CNT_W  good test frames.
- cnt_lost_o  out  CNT_W  frames missing by sequence gap.
- cnt_ooo_o  out  CNT_W  out-of-order/duplicate frames.
- cnt_err_o  out  CNT_W  test frames dropped (MAC error or runt).
- cnt_other_o  out  CNT_W  non-test frames ignored.

Behaviour:
- **Reset values:** all outputs 0. snk_ready_o is 0 during reset, then 1 from the first cycle after srst_i deasserts. The block never backpressures.
- **Transfers:** a beat is accepted when snk_valid_i && snk_ready_o.
- **Frame word layout:**
  - w0: 2 pad bytes + dst[47:32]
  - w1: dst[31:0]
  - w2: src[47:16]
  - w3: src[15:0] + EtherType in [15:0]
  - w4: seq[31:0]
  - w5: ts[63:32]
  - w6: ts[31:0]
  - further words are ignored.
- **FSM states:** IDLE, HDR, SEQ, TSH, TSL, DRAIN, DROP.
  - IDLE: sop beat -> HDR with word counter = 1. Non-sop beats are ignored.
  - HDR: counts w1..w3. On w3, if [15:0] != ETHERTYPE -> DROP as "other"; else -> SEQ.
  - SEQ, TSH, TSL: latch seq, ts_hi and ts_lo respectively. After TSL -> DRAIN. If TSL carries eop, treat it as the DRAIN eop.
  - DRAIN: wait for eop.
  - DROP: wait for eop, then -> IDLE.
- **Runt frame:** eop in any state before TSL completes -> cnt_err_o++ if EtherType was already matched; otherwise cnt_other_o++. Then -> IDLE.
- **Unexpected sop:** sop while not in IDLE aborts the current frame with the same accounting as a runt, then restarts at HDR with word counter = 1 on that beat.
- **Eop of a matched frame:**
  - Any snk_error_i bit set -> cnt_err_o++, no result.
  - Otherwise compute diff = ts_i − ts_rx mod 2^64, with ts_i sampled on the eop cycle.
  - res_delay_o = diff if diff < 2^32, else 32'hFFFFFFFF.
  - res_valid_o pulses exactly 1 cycle after the eop beat; res_seq_o/res_delay_o are held until the next result.
  - cnt_rx_o++.
- **Sequence tracking** (only on good frames):
  - First good frame after reset: exp = seq+1, no loss.
  - seq == exp -> exp = seq+1.
  - seq > exp -> cnt_lost_o += seq−exp, exp = seq+1.
  - seq < exp -> cnt_ooo_o++, exp unchanged.
  - Comparison is unsigned 32-bit; seq wrap 32'hFFFFFFFF -> 0 is in order (exp wraps).
- **Counters** saturate at all-ones; no wrap.
- **Reset mid-frame:** FSM returns to IDLE, counters clear, first-frame flag is set again. The remainder of the interrupted frame is ignored because no sop is seen.

Optional Feature:
- Macro: DELAY_PROBE_DST_FILTER_EN.
- Defined: on w0/w1 the destination MAC is compared with LOCAL_MAC. On mismatch, at w1 -> DROP and count as other, even if EtherType would match.
- Undefined: the destination MAC is not inspected.

Test Plan:
- **Good frame:** seq=5, ts_tx=1000, ts_i=1250 at eop, after reset -> res_valid_o pulse 1 cycle after eop, res_seq_o=5, res_delay_o=250, cnt_rx_o=1, cnt_lost_o=0.
- **Gap and out-of-order:** seqs 10,11,14,12 -> cnt_rx_o=4, cnt_lost_o=2, cnt_ooo_o=1.
- **Seq wrap:** seqs 32'hFFFFFFFF then 0 -> cnt_lost_o=0, cnt_ooo_o=0.
- **Bad frames:**
  - EtherType 16'h0800 -> cnt_other_o=1, no res_valid_o.
  - Matched frame with snk_error_i=6'h02 on eop -> cnt_err_o=1, no result.
  - Eop on w5 (runt) -> cnt_err_o=2.
- **Saturation / reset:** ts_tx=0, ts_i=2^33 -> res_delay_o=32'hFFFFFFFF. Then sop mid-frame -> old frame counted as err, new frame measured normally. srst_i asserted on w4 -> all counters 0 and no result emitted.
- **DST filter (DELAY_PROBE_DST_FILTER_EN defined):**
  - LOCAL_MAC=48'h001122334455, frame to 48'h001122334456 -> cnt_other_o=1.
  - Frame to 48'h001122334455 -> result produced.

Source files
------------

// File: rtl/delay_probe_rx.sv
// delay_probe_rx: receive side of the delay-test frame pair.
// Parses test frames from a 32-bit SHIFT16 Avalon-ST stream, measures the delay from the
// embedded 64-bit transmit timestamp to the local timestamp, and keeps CSR statistics.
// Optional build macro: DELAY_PROBE_DST_FILTER_EN. When it is defined, frames whose
// destination MAC differs from LOCAL_MAC are dropped and counted as "other".
module delay_probe_rx #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [47:0] LOCAL_MAC = 48'h0000_0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [63:0]      ts_i,
  input  logic [31:0]      snk_data_i,
  input  logic             snk_valid_i,
  input  logic             snk_sop_i,
  input  logic             snk_eop_i,
  input  logic [1:0]       snk_empty_i,
  input  logic [5:0]       snk_error_i,
  output logic             snk_ready_o,
  output logic             res_valid_o,
  output logic [31:0]      res_seq_o,
  output logic [31:0]      res_delay_o,
  output logic [CNT_W-1:0] cnt_rx_o,
  output logic [CNT_W-1:0] cnt_lost_o,
  output logic [CNT_W-1:0] cnt_ooo_o,
  output logic [CNT_W-1:0] cnt_err_o,
  output logic [CNT_W-1:0] cnt_other_o
);

  // Adder width large enough for any counter plus a 32-bit sequence gap.
  localparam int unsigned AW = ((CNT_W > 32) ? CNT_W : 32) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_TSH,
    S_TSL,
    S_DRAIN,
    S_DROP
  } state_e;

  // Saturating add of a 32-bit amount to a statistics counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [31:0]      b);
    logic [AW-1:0] sum;
    sum = {{(AW-CNT_W){1'b0}}, a} + {{(AW-32){1'b0}}, b};
    if (sum > {{(AW-CNT_W){1'b0}}, CNT_MAX}) return CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic             ready_q, ready_d;

  logic [31:0]      seq_q, seq_d;
  logic [31:0]      ts_hi_q, ts_hi_d;
  logic [31:0]      ts_lo_q, ts_lo_d;
  logic             first_q, first_d;
  logic [31:0]      exp_q, exp_d;

  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_seq_q, res_seq_d;
  logic [31:0]      res_delay_q, res_delay_d;

  logic [CNT_W-1:0] cnt_rx_q, cnt_rx_d;
  logic [CNT_W-1:0] cnt_lost_q, cnt_lost_d;
  logic [CNT_W-1:0] cnt_ooo_q, cnt_ooo_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  logic [CNT_W-1:0] cnt_other_q, cnt_other_d;

  // ---------------------------------------------------------------------------
  // Beat qualification and field decode
  // ---------------------------------------------------------------------------
  logic beat, sop_b, eop_b, etype_ok, dst_lo_ok;

  assign beat     = snk_valid_i & ready_q;
  assign sop_b    = beat & snk_sop_i;
  assign eop_b    = beat & snk_eop_i;
  assign etype_ok = (snk_data_i[15:0] == ETHERTYPE);

  // Empty bytes on the eop word do not matter: every parsed field sits in full words.
  logic unused_empty;
  assign unused_empty = ^snk_empty_i;

`ifdef DELAY_PROBE_DST_FILTER_EN
  logic dst_hi_ok_q, dst_hi_ok_d;
  logic dst_hi_en;

  // Capture the w0 half of the destination compare; w1 completes it.
  always_comb begin
    dst_hi_ok_d = dst_hi_ok_q;
    if (dst_hi_en) dst_hi_ok_d = (snk_data_i[15:0] == LOCAL_MAC[47:32]);
  end

  // Destination compare flag register.
  always_ff @(posedge clk_i) begin
    if (srst_i) dst_hi_ok_q <= 1'b0;
    else        dst_hi_ok_q <= dst_hi_ok_d;
  end

  assign dst_lo_ok = dst_hi_ok_q && (snk_data_i == LOCAL_MAC[31:0]);
`else
  logic dst_hi_en;
  logic unused_dst;
  assign dst_lo_ok  = 1'b1;
  assign unused_dst = ^{LOCAL_MAC, dst_hi_en};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // Parser state, header word counter and sink-ready register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    if (srst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // A sop always restarts parsing at w1; otherwise walk the fixed word layout.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ready_d = 1'b1;
    if (sop_b) begin
      state_d = eop_b ? S_IDLE : S_HDR;
      wcnt_d  = 2'd1;
    end else if (beat) begin
      unique case (state_q)
        S_IDLE: ;
        S_HDR: begin
          if (eop_b)                              state_d = S_IDLE;
          else if (wcnt_q == 2'd1 && !dst_lo_ok)  state_d = S_DROP;
          else if (wcnt_q == 2'd3)                state_d = etype_ok ? S_SEQ : S_DROP;
          else                                    wcnt_d  = wcnt_q + 2'd1;
        end
        S_SEQ:   state_d = eop_b ? S_IDLE : S_TSH;
        S_TSH:   state_d = eop_b ? S_IDLE : S_TSL;
        S_TSL:   state_d = eop_b ? S_IDLE : S_DRAIN;
        S_DRAIN: if (eop_b) state_d = S_IDLE;
        S_DROP:  if (eop_b) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (field latch enables and accounting events)
  // ---------------------------------------------------------------------------
  logic [1:0] err_add, other_add;
  logic       seq_en, tsh_en, tsl_en, frame_good;

  // Decide, per beat, which field to latch and which counter a frame lands in.
  always_comb begin
    err_add    = 2'd0;
    other_add  = 2'd0;
    seq_en     = 1'b0;
    tsh_en     = 1'b0;
    tsl_en     = 1'b0;
    frame_good = 1'b0;
    dst_hi_en  = 1'b0;
    if (sop_b) begin
      // Abort of the frame in progress. DROP frames were already counted on entry.
      unique case (state_q)
        S_HDR:                        other_add = 2'd1;
        S_SEQ, S_TSH, S_TSL, S_DRAIN: err_add   = 2'd1;
        default: ;
      endcase
      dst_hi_en = 1'b1;
      // A single-beat frame is a runt that never reached its EtherType.
      if (eop_b) other_add = other_add + 2'd1;
    end else if (beat) begin
      unique case (state_q)
        S_HDR: begin
          if (eop_b) begin
            if (wcnt_q == 2'd3 && etype_ok) err_add   = 2'd1;
            else                            other_add = 2'd1;
          end else if ((wcnt_q == 2'd1 && !dst_lo_ok) ||
                       (wcnt_q == 2'd3 && !etype_ok)) begin
            other_add = 2'd1;
          end
        end
        S_SEQ: begin
          if (eop_b) err_add = 2'd1;
          else       seq_en  = 1'b1;
        end
        S_TSH: begin
          if (eop_b) err_add = 2'd1;
          else       tsh_en  = 1'b1;
        end
        S_TSL, S_DRAIN: begin
          tsl_en = (state_q == S_TSL);
          if (eop_b) begin
            if (|snk_error_i) err_add    = 2'd1;
            else              frame_good = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Delay computation
  // ---------------------------------------------------------------------------
  logic [31:0] ts_lo_now;
  logic [63:0] diff;
  logic [31:0] delay_sat;

  // The low timestamp word may arrive on the eop beat itself, so bypass its register.
  assign ts_lo_now = (state_q == S_TSL) ? snk_data_i : ts_lo_q;
  assign diff      = ts_i - {ts_hi_q, ts_lo_now};
  assign delay_sat = (diff[63:32] != 32'd0) ? 32'hFFFF_FFFF : diff[31:0];

  // ---------------------------------------------------------------------------
  // Datapath: fields, sequence tracking, results and statistics
  // ---------------------------------------------------------------------------
  // Next values for latched fields, expected sequence, result and counters.
  always_comb begin
    seq_d       = seq_q;
    ts_hi_d     = ts_hi_q;
    ts_lo_d     = ts_lo_q;
    first_d     = first_q;
    exp_d       = exp_q;
    res_valid_d = 1'b0;
    res_seq_d   = res_seq_q;
    res_delay_d = res_delay_q;
    cnt_rx_d    = cnt_rx_q;
    cnt_lost_d  = cnt_lost_q;
    cnt_ooo_d   = cnt_ooo_q;
    cnt_err_d   = sat_add(cnt_err_q, {30'd0, err_add});
    cnt_other_d = sat_add(cnt_other_q, {30'd0, other_add});

    if (seq_en) seq_d   = snk_data_i;
    if (tsh_en) ts_hi_d = snk_data_i;
    if (tsl_en) ts_lo_d = snk_data_i;

    if (frame_good) begin
      res_valid_d = 1'b1;
      res_seq_d   = seq_q;
      res_delay_d = delay_sat;
      cnt_rx_d    = sat_add(cnt_rx_q, 32'd1);
      // Unsigned compare; exp wraps with seq so FFFFFFFF -> 0 stays in order.
      if (first_q || seq_q == exp_q) begin
        exp_d   = seq_q + 32'd1;
        first_d = 1'b0;
      end else if (seq_q > exp_q) begin
        cnt_lost_d = sat_add(cnt_lost_q, seq_q - exp_q);
        exp_d      = seq_q + 32'd1;
      end else begin
        cnt_ooo_d = sat_add(cnt_ooo_q, 32'd1);
      end
    end
  end

  // Datapath registers; reset clears all outputs and re-arms the first-frame flag.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      seq_d_unused_guard: begin end
      seq_q       <= 32'd0;
      ts_hi_q     <= 32'd0;
      ts_lo_q     <= 32'd0;
      first_q     <= 1'b1;
      exp_q       <= 32'd0;
      res_valid_q <= 1'b0;
      res_seq_q   <= 32'd0;
      res_delay_q <= 32'd0;
      cnt_rx_q    <= '0;
      cnt_lost_q  <= '0;
      cnt_ooo_q   <= '0;
      cnt_err_q   <= '0;
      cnt_other_q <= '0;
    end else begin
      seq_q       <= seq_d;
      ts_hi_q     <= ts_hi_d;
      ts_lo_q     <= ts_lo_d;
      first_q     <= first_d;
      exp_q       <= exp_d;
      res_valid_q <= res_valid_d;
      res_seq_q   <= res_seq_d;
      res_delay_q <= res_delay_d;
      cnt_rx_q    <= cnt_rx_d;
      cnt_lost_q  <= cnt_lost_d;
      cnt_ooo_q   <= cnt_ooo_d;
      cnt_err_q   <= cnt_err_d;
      cnt_other_q <= cnt_other_d;
    end
  end

  assign snk_ready_o = ready_q;
  assign res_valid_o = res_valid_q;
  assign res_seq_o   = res_seq_q;
  assign res_delay_o = res_delay_q;
  assign cnt_rx_o    = cnt_rx_q;
  assign cnt_lost_o  = cnt_lost_q;
  assign cnt_ooo_o   = cnt_ooo_q;
  assign cnt_err_o   = cnt_err_q;
  assign cnt_other_o = cnt_other_q;

endmodule
